// File: rtl/synch_counter_pkg.sv
// rtl/synch_counter_pkg.sv - shared width, count type and default reset value for synch_counter
package synch_counter_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_RST = '0;

endpackage : synch_counter_pkg

// File: rtl/synch_counter_tff.sv
// rtl/synch_counter_tff.sv - one counter stage: T flip-flop with async active-low clear to rst_bit
module synch_counter_tff (
    input  logic clk,
    input  logic clear,
    input  logic t,
    input  logic rst_bit,
    output logic q
);

    logic q_q;
    logic q_d;

    // Toggle when enabled, otherwise hold.
    always_comb begin
        q_d = q_q ^ t;
    end

    // State bit; clear low forces the stage to its reset bit without waiting for a clock.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q_q <= rst_bit;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : synch_counter_tff

// File: rtl/synch_counter.sv
// rtl/synch_counter.sv - 4-bit synchronous up-counter from a T flip-flop chain; optional tc via SYNCH_COUNTER_TC_EN
module synch_counter
    import synch_counter_pkg::*;
#(
    parameter cnt_t RST_VAL = CNT_RST
) (
    input  logic clk,
    input  logic clear,
    input  logic count,
    output logic q0,
    output logic q1,
    output logic q2,
`ifdef SYNCH_COUNTER_TC_EN
    output logic q3,
    output logic tc
`else
    output logic q3
`endif
);

    cnt_t q_vec;
    cnt_t t_en;

    // Toggle enables: each stage flips only when count is high and every lower bit is 1.
    always_comb begin
        t_en[0] = count;
        for (int i = 1; i < CNT_W; i++) begin
            t_en[i] = t_en[i-1] & q_vec[i-1];
        end
    end

    for (genvar g = 0; g < CNT_W; g++) begin : g_stage
        synch_counter_tff u_tff (
            .clk     (clk),
            .clear   (clear),
            .t       (t_en[g]),
            .rst_bit (RST_VAL[g]),
            .q       (q_vec[g])
        );
    end

    assign q0 = q_vec[0];
    assign q1 = q_vec[1];
    assign q2 = q_vec[2];
    assign q3 = q_vec[3];

`ifdef SYNCH_COUNTER_TC_EN
    // Terminal count: high while all ones and enabled, i.e. the cycle before wrap; drives a cascaded count input.
    assign tc = t_en[CNT_W-1] & q_vec[CNT_W-1];
`endif

endmodule : synch_counter

// File: tb/tb_synch_counter.sv
// tb/tb_synch_counter.sv - directed self-checking bench for synch_counter (default and RST_VAL=4'b1010 instances)
module tb_synch_counter;

    logic clk;
    logic clear;
    logic count;
    logic q0, q1, q2, q3;
    logic clear_rv;
    logic count_rv;
    logic r0, r1, r2, r3;
`ifdef SYNCH_COUNTER_TC_EN
    logic tc;
    logic tc_rv;
`endif

    int nvec;
    int nfail;

    synch_counter u_dut (
        .clk   (clk),
        .clear (clear),
        .count (count),
        .q0    (q0),
        .q1    (q1),
        .q2    (q2),
`ifdef SYNCH_COUNTER_TC_EN
        .q3    (q3),
        .tc    (tc)
`else
        .q3    (q3)
`endif
    );

    synch_counter #(.RST_VAL(4'b1010)) u_dut_rv (
        .clk   (clk),
        .clear (clear_rv),
        .count (count_rv),
        .q0    (r0),
        .q1    (r1),
        .q2    (r2),
`ifdef SYNCH_COUNTER_TC_EN
        .q3    (r3),
        .tc    (tc_rv)
`else
        .q3    (r3)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [3:0] qv();
        return {q3, q2, q1, q0};
    endfunction

    function automatic logic [3:0] rv();
        return {r3, r2, r1, r0};
    endfunction

    task automatic test_reset();
        #1 clear = 1'b0;
        #2;
        nvec++;
        if (qv() !== 4'd0) begin
            nfail++;
            $display("FAIL reset_async: got %0d expected 0", qv());
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) count = 1'b1;
            nvec++;
            if (qv() !== 4'd0) begin
                nfail++;
                $display("FAIL reset_hold[%0d]: got %0d expected 0", i, qv());
            end
        end
    endtask

    task automatic test_count_up();
        @(negedge clk);
        clear = 1'b1;
        count = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            nvec++;
            if (qv() !== 4'(i)) begin
                nfail++;
                $display("FAIL count_up[%0d]: got %0d expected %0d", i, qv(), i);
            end
`ifdef SYNCH_COUNTER_TC_EN
            nvec++;
            if (tc !== (i == 15)) begin
                nfail++;
                $display("FAIL tc_count[%0d]: got %b expected %b", i, tc, (i == 15));
            end
`endif
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        nvec++;
        if (qv() !== 4'd0) begin
            nfail++;
            $display("FAIL wrap: got %0d expected 0", qv());
        end
`ifdef SYNCH_COUNTER_TC_EN
        nvec++;
        if (tc !== 1'b0) begin
            nfail++;
            $display("FAIL tc_after_wrap: got %b expected 0", tc);
        end
`endif
    endtask

    task automatic test_hold();
        repeat (5) @(negedge clk);
        nvec++;
        if (qv() !== 4'd5) begin
            nfail++;
            $display("FAIL hold_start: got %0d expected 5", qv());
        end
        count = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3 count = 1'b1;
            #2 count = 1'b0;
            @(negedge clk);
            nvec++;
            if (qv() !== 4'd5) begin
                nfail++;
                $display("FAIL hold[%0d]: got %0d expected 5", i, qv());
            end
        end
        count = 1'b1;
        @(negedge clk);
        nvec++;
        if (qv() !== 4'd6) begin
            nfail++;
            $display("FAIL hold_resume: got %0d expected 6", qv());
        end
    endtask

    task automatic test_async_clear();
        repeat (3) @(negedge clk);
        nvec++;
        if (qv() !== 4'd9) begin
            nfail++;
            $display("FAIL pre_clear: got %0d expected 9", qv());
        end
        #2 clear = 1'b0;
        #1;
        nvec++;
        if (qv() !== 4'd0) begin
            nfail++;
            $display("FAIL clear_immediate: got %0d expected 0", qv());
        end
        #2 clear = 1'b1;
        @(negedge clk);
        nvec++;
        if (qv() !== 4'd1) begin
            nfail++;
            $display("FAIL clear_restart: got %0d expected 1", qv());
        end
    endtask

    task automatic test_rst_val();
        logic [3:0] exp_seq [6];
        exp_seq = '{4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
        @(negedge clk);
        clear_rv = 1'b0;
        #1;
        nvec++;
        if (rv() !== 4'd10) begin
            nfail++;
            $display("FAIL rv_reset: got %0d expected 10", rv());
        end
        count_rv = 1'b1;
        repeat (2) @(negedge clk);
        nvec++;
        if (rv() !== 4'd10) begin
            nfail++;
            $display("FAIL rv_hold: got %0d expected 10", rv());
        end
        clear_rv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nvec++;
            if (rv() !== exp_seq[i]) begin
                nfail++;
                $display("FAIL rv_count[%0d]: got %0d expected %0d", i, rv(), exp_seq[i]);
            end
        end
    endtask

    initial begin
        nvec     = 0;
        nfail    = 0;
        clear    = 1'b1;
        count    = 1'b0;
        clear_rv = 1'b1;
        count_rv = 1'b0;
        test_reset();
        test_count_up();
        test_wrap();
        test_hold();
        test_async_clear();
        test_rst_val();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule : tb_synch_counter
